// File: rtl/dac_stream_pkg.sv
// Shared types and helpers for the DAC output stage: mode encoding, sizing and
// the per-sample saturating adder used by the SUM path.
package dac_stream_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int SAMPLES_PER_BEAT = 16;
  localparam int AXIS_DATA_WIDTH  = SAMPLE_WIDTH * SAMPLES_PER_BEAT;
  localparam int FIFO_DEPTH       = 16;

  typedef enum logic [1:0] {
    DDS    = 2'b00,
    DIRECT = 2'b01,
    SUM    = 2'b10,
    MUTE   = 2'b11
  } dac_mode_t;

  // Signed add clamped to the representable range of one sample.
  function automatic logic [SAMPLE_WIDTH-1:0] sat_add(input logic [SAMPLE_WIDTH-1:0] a,
                                                      input logic [SAMPLE_WIDTH-1:0] b);
    logic [SAMPLE_WIDTH:0] s;
    s = {a[SAMPLE_WIDTH-1], a} + {b[SAMPLE_WIDTH-1], b};
    if (s[SAMPLE_WIDTH] != s[SAMPLE_WIDTH-1])
      return s[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    return s[SAMPLE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Direct-sample FIFO. The caller only asserts pop when non-empty and push when
// there is room (or a pop frees a slot the same cycle); flush overrides both.
module dac_sample_fifo
  import dac_stream_pkg::*;
#(
  parameter int WIDTH = AXIS_DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    full_d  = (level_d == (AW+1)'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/dac_stream_selector.sv
// DAC output stage: per-beat selection of DDS, direct FIFO samples, their
// saturated sum, or silence, behind a registered AXIS master.
module dac_stream_selector
  import dac_stream_pkg::*;
#(
  localparam int SW      = SAMPLE_WIDTH,
  localparam int SPB     = SAMPLES_PER_BEAT,
  localparam int DW      = AXIS_DATA_WIDTH,
  localparam int FIFO_AW = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode_in,
  input  logic               mode_valid,
  input  logic               flush,
  input  logic [DW-1:0]      dds_tdata,
  input  logic               dds_tvalid,
  input  logic [DW-1:0]      direct_wdata,
  input  logic               direct_write,
  output logic               direct_full,
  output logic [FIFO_AW:0]   direct_level,
  output logic [DW-1:0]      m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [1:0]         active_mode,
  input  logic               clear_error,
  output logic               overflow,
  output logic               underflow
);

  dac_mode_t     pending_q, pending_d;
  dac_mode_t     active_q, active_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_rdata, fifo_head, sum_beat, beat;
  logic          src_valid, load, uses_fifo, underflow_set, overflow_set;

  dac_sample_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .wdata (direct_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (direct_level)
  );

  // AXIS master: a beat transfers when tvalid & tready; once tvalid is high,
  // tdata and tvalid stay frozen until tready is seen.
  always_comb begin
    src_valid     = (pending_q == DDS || pending_q == SUM) ? dds_tvalid : 1'b1;
    load          = (!tvalid_q || m_axis_tready) && src_valid;
    uses_fifo     = (pending_q == DIRECT || pending_q == SUM);
    fifo_pop      = load && uses_fifo && !fifo_empty;
    underflow_set = load && uses_fifo && fifo_empty;
    fifo_push     = direct_write && !flush && (!fifo_full || fifo_pop);
    overflow_set  = direct_write && !flush && fifo_full && !fifo_pop;
    fifo_head     = fifo_empty ? '0 : fifo_rdata;

    sum_beat = '0;
    for (int i = 0; i < SPB; i++)
      sum_beat[i*SW +: SW] = sat_add(dds_tdata[i*SW +: SW], fifo_head[i*SW +: SW]);

    case (pending_q)
      DDS:     beat = dds_tdata;
      DIRECT:  beat = fifo_head;
      SUM:     beat = sum_beat;
      default: beat = '0;
    endcase

    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    active_d = active_q;
    if (load) begin
      tdata_d  = beat;
      tvalid_d = 1'b1;
      active_d = pending_q;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    pending_d   = mode_valid ? dac_mode_t'(mode_in) : pending_q;
    overflow_d  = overflow_set  ? 1'b1 : (clear_error ? 1'b0 : overflow_q);
    underflow_d = underflow_set ? 1'b1 : (clear_error ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= DDS;
      active_q    <= DDS;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      active_q    <= active_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign active_mode   = active_q;
  assign direct_full   = fifo_full;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_dac_stream_selector.sv
// Directed plus randomized bench for dac_stream_selector, checked against a
// queue-based reference model of the selector behaviour.
module tb_dac_stream_selector;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   mode_in = 2'd0;
  logic         mode_valid = 1'b0;
  logic         flush = 1'b0;
  logic [255:0] dds_tdata = '0;
  logic         dds_tvalid = 1'b0;
  logic [255:0] direct_wdata = '0;
  logic         direct_write = 1'b0;
  logic         direct_full;
  logic [4:0]   direct_level;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic [1:0]   active_mode;
  logic         clear_error = 1'b0;
  logic         overflow;
  logic         underflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [255:0] fifo_m[$];
  logic [1:0]   m_pending, m_active;
  logic [255:0] m_tdata;
  logic         m_tvalid, m_ovf, m_unf;
  logic [255:0] beats[4];

  dac_stream_selector dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .mode_valid(mode_valid), .flush(flush),
    .dds_tdata(dds_tdata), .dds_tvalid(dds_tvalid), .direct_wdata(direct_wdata),
    .direct_write(direct_write), .direct_full(direct_full), .direct_level(direct_level),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .active_mode(active_mode), .clear_error(clear_error), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_beat();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] splat(input logic [15:0] s);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = s;
    return r;
  endfunction

  // Per-sample signed sum clamped to the 16-bit range, in plain integers.
  function automatic logic [255:0] ref_sum(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [15:0]  sa, sb;
    int s;
    for (int i = 0; i < 16; i++) begin
      sa = a[i*16 +: 16];
      sb = b[i*16 +: 16];
      s = int'($signed(sa)) + int'($signed(sb));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      r[i*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    m_pending = 2'd0; m_active = 2'd0; m_tdata = '0;
    m_tvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic         takes_fifo, go, popping;
    logic [255:0] head, val;
    int           sz;
    sz         = fifo_m.size();
    takes_fifo = (m_pending == 2'd1) || (m_pending == 2'd2);
    go         = (!m_tvalid || m_axis_tready) &&
                 (((m_pending == 2'd0) || (m_pending == 2'd2)) ? dds_tvalid : 1'b1);
    head       = (sz > 0) ? fifo_m[0] : '0;
    popping    = go && takes_fifo && (sz > 0);
    case (m_pending)
      2'd0:    val = dds_tdata;
      2'd1:    val = head;
      2'd2:    val = ref_sum(dds_tdata, head);
      default: val = '0;
    endcase
    if (popping) void'(fifo_m.pop_front());
    if (flush) fifo_m.delete();
    else if (direct_write) begin
      if (sz < 16 || popping) fifo_m.push_back(direct_wdata);
      else m_ovf = 1'b1;
    end
    if (go && takes_fifo && sz == 0) m_unf = 1'b1;
    else if (clear_error) m_unf = 1'b0;
    if (!(direct_write && !flush && sz == 16 && !popping) && clear_error) m_ovf = 1'b0;
    if (go) begin
      m_tdata = val; m_tvalid = 1'b1; m_active = m_pending;
    end else if (m_axis_tready) m_tvalid = 1'b0;
    if (mode_valid) m_pending = mode_in;
  endtask

  task automatic compare_all();
    check("tvalid", 256'(m_axis_tvalid), 256'(m_tvalid));
    if (m_tvalid) begin
      check("tdata", m_axis_tdata, m_tdata);
      check("active_mode", 256'(active_mode), 256'(m_active));
    end
    check("direct_level", 256'(direct_level), 256'(fifo_m.size()));
    check("direct_full", 256'(direct_full), 256'(fifo_m.size() == 16));
    check("overflow", 256'(overflow), 256'(m_ovf));
    check("underflow", 256'(underflow), 256'(m_unf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    mode_valid = 1'b0; direct_write = 1'b0; flush = 1'b0; clear_error = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_in = m; mode_valid = 1'b1;
    tick();
  endtask

  task automatic push(input logic [255:0] d);
    direct_wdata = d; direct_write = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    model_reset();
    #2;
    check("reset_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("reset_tdata", m_axis_tdata, 256'(0));
    check("reset_active", 256'(active_mode), 256'(0));
    check("reset_level", 256'(direct_level), 256'(0));
    @(posedge clk); #1; reset = 1'b0;
    compare_all();

    // DDS pass-through: ramp with one cycle of latency
    dds_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dds_tdata = splat(16'(i * 3 + 1));
      tick();
      check("dds_ramp", m_axis_tdata, splat(16'(i * 3 + 1)));
    end

    // DIRECT: four beats out in order, then an underflowing load
    for (int i = 0; i < 4; i++) begin
      beats[i] = rand_beat();
      push(beats[i]);
    end
    set_mode(2'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("direct_order", m_axis_tdata, beats[i]);
    end
    tick();
    check("direct_empty_data", m_axis_tdata, 256'(0));
    check("direct_underflow", 256'(underflow), 256'(1));
    check("direct_level0", 256'(direct_level), 256'(0));
    clear_error = 1'b1; tick();

    // SUM saturation at both rails
    set_mode(2'd3);
    push(splat(16'h0020));
    push(splat(16'hFFF0));
    dds_tdata = splat(16'h7FF0);
    set_mode(2'd2);
    tick();
    check("sum_pos_sat", m_axis_tdata, splat(16'h7FFF));
    dds_tdata = splat(16'h8005);
    tick();
    check("sum_neg_sat", m_axis_tdata, splat(16'h8000));

    // Back-pressure in DIRECT holds data and pops nothing
    set_mode(2'd3);
    for (int i = 0; i < 3; i++) begin
      beats[i] = rand_beat();
      push(beats[i]);
    end
    set_mode(2'd1);
    tick();
    check("bp_first", m_axis_tdata, beats[0]);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", m_axis_tdata, beats[0]);
      check("bp_hold_level", 256'(direct_level), 256'(2));
    end
    m_axis_tready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      check("bp_resume", m_axis_tdata, beats[i]);
    end

    // Full FIFO: overflow, clear, then push+pop at full
    flush = 1'b1;
    set_mode(2'd3);
    for (int i = 0; i < 16; i++) push(rand_beat());
    check("fill_full", 256'(direct_full), 256'(1));
    check("fill_level", 256'(direct_level), 256'(16));
    push(rand_beat());
    check("ovf_set", 256'(overflow), 256'(1));
    check("ovf_level", 256'(direct_level), 256'(16));
    clear_error = 1'b1; tick();
    check("ovf_clear", 256'(overflow), 256'(0));
    set_mode(2'd1);
    for (int i = 0; i < 3; i++) begin
      push(rand_beat());
      check("pushpop_level", 256'(direct_level), 256'(16));
      check("pushpop_no_ovf", 256'(overflow), 256'(0));
    end
    // Flush with a simultaneous write drops it silently
    flush = 1'b1; direct_wdata = rand_beat(); direct_write = 1'b1; tick();
    check("flush_level", 256'(direct_level), 256'(0));
    check("flush_no_ovf", 256'(overflow), 256'(0));

    // Mode switch under back-pressure applies on the next accepted load
    set_mode(2'd0);
    tick();
    m_axis_tready = 1'b0;
    set_mode(2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("switch_held_mode", 256'(active_mode), 256'(0));
    end
    m_axis_tready = 1'b1;
    tick();
    check("switch_mode", 256'(active_mode), 256'(3));
    check("switch_mute", m_axis_tdata, 256'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode_in      = 2'($urandom_range(0, 3));
      mode_valid   = ($urandom_range(0, 7) == 0);
      direct_write = ($urandom_range(0, 1) == 1);
      direct_wdata = rand_beat();
      flush        = ($urandom_range(0, 31) == 0);
      clear_error  = ($urandom_range(0, 15) == 0);
      dds_tvalid   = ($urandom_range(0, 3) != 0);
      dds_tdata    = rand_beat();
      m_axis_tready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset mid-burst drops tvalid without a clock edge
    set_mode(2'd0);
    dds_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dds_tdata = rand_beat();
      tick();
    end
    #2; reset = 1'b1; #1;
    check("async_reset_tvalid", 256'(m_axis_tvalid), 256'(0));
    model_reset();
    compare_all();
    @(posedge clk); #1; reset = 1'b0;
    compare_all();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
